tlb_inv_walker: RTL and testbench

TLB_INV_WALKER -- requirements
Module: tlb_inv_walker

---
 rtl/tlb_inv_walker_pkg.sv | 29 ++
 rtl/tlb_inv_match.sv | 45 ++++
 rtl/tlb_inv_walker.sv | 124 ++++++++++++
 tb/tb_tlb_inv_walker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_inv_walker_pkg.sv
// Shared CPU definitions used by the TLB, decode and the INVTLB walker:
// INVTLB op codes, default TLB depth, page-size encodings and walker states.
package tlb_inv_walker_pkg;

  localparam int TLBNUM_DEF = 16;

  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GASID_VA   = 5'd6;
  localparam logic [4:0] INV_OP_MAX     = INV_GASID_VA;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_DONE
  } walk_state_e;

  function automatic logic inv_op_legal(input logic [4:0] op);
    return op <= INV_OP_MAX;
  endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB predicate: decides whether the TLB entry currently
// presented on the read port must have its E bit cleared for the given op.
module tlb_inv_match
  import tlb_inv_walker_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [9:0]  asid,
  input  logic [18:0] vppn,
  input  logic        rd_e,
  input  logic        rd_g,
  input  logic [9:0]  rd_asid,
  input  logic [18:0] rd_vppn,
  input  logic [5:0]  rd_ps,
  output logic        hit
);

  logic asid_eq;
  logic va_match;
  logic pred;

  assign asid_eq = (rd_asid == asid);

  // A 4MB page only compares VA[31:22]; unknown page sizes never match.
  always_comb begin
    va_match = 1'b0;
    if (rd_ps == PS_4K)      va_match = (rd_vppn == vppn);
    else if (rd_ps == PS_4M) va_match = (rd_vppn[18:9] == vppn[18:9]);
  end

  always_comb begin
    pred = 1'b0;
    case (op)
      INV_ALL0, INV_ALL1: pred = 1'b1;
      INV_G:              pred = rd_g;
      INV_NG:             pred = !rd_g;
      INV_NG_ASID:        pred = !rd_g && asid_eq;
      INV_NG_ASID_VA:     pred = !rd_g && asid_eq && va_match;
      INV_GASID_VA:       pred = (rd_g || asid_eq) && va_match;
      default:            pred = 1'b0;
    endcase
  end

  assign hit = rd_e && pred;

endmodule

// File: rtl/tlb_inv_walker.sv
// INVTLB walker: captures an INVTLB request, sweeps every TLB index once
// through the read port and clears E on entries matching the op predicate.
module tlb_inv_walker
  import tlb_inv_walker_pkg::*;
#(
  parameter int TLBNUM = TLBNUM_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [4:0]                req_op,
  input  logic [9:0]                req_asid,
  input  logic [31:0]               req_va,
  input  logic                      cancel,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(TLBNUM)-1:0] rd_idx,
  input  logic                      rd_e,
  input  logic                      rd_g,
  input  logic [9:0]                rd_asid,
  input  logic [18:0]               rd_vppn,
  input  logic [5:0]                rd_ps,
  output logic                      clr_we,
  output logic [$clog2(TLBNUM)-1:0] clr_idx
);

  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

  walk_state_e     state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic [9:0]      asid_q, asid_d;
  logic [18:0]     vppn_q, vppn_d;
  // Holds req_ready low until the first edge after reset release.
  logic            init_q;
  logic            hit;
  logic            unused_va_lo;

  assign unused_va_lo = ^req_va[12:0];

  tlb_inv_match u_match (
    .op      (op_q),
    .asid    (asid_q),
    .vppn    (vppn_q),
    .rd_e    (rd_e),
    .rd_g    (rd_g),
    .rd_asid (rd_asid),
    .rd_vppn (rd_vppn),
    .rd_ps   (rd_ps),
    .hit     (hit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      asid_q  <= asid_d;
      vppn_q  <= vppn_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    asid_d    = asid_q;
    vppn_d    = vppn_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    clr_we    = 1'b0;
    clr_idx   = '0;
    rd_idx    = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = init_q;
        if (req_valid && init_q) begin
          op_d    = req_op;
          asid_d  = req_asid;
          vppn_d  = req_va[31:13];
          cnt_d   = '0;
          state_d = inv_op_legal(req_op) ? ST_WALK : ST_DONE;
        end
      end
      ST_WALK: begin
        busy   = 1'b1;
        rd_idx = cnt_q;
        if (cancel) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          clr_we  = hit;
          clr_idx = hit ? cnt_q : '0;
          cnt_d   = cnt_q + IDXW'(1);
          if (cnt_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
        if (!cancel) begin
          done = 1'b1;
          err  = !inv_op_legal(op_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_inv_walker.sv
// Directed bench for tlb_inv_walker: table of INVTLB requests against fixed
// TLB images, plus hand sequences for reset, cancel and mid-walk reset.
module tb_tlb_inv_walker;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [9:0]  req_asid;
  logic [31:0] req_va;
  logic        cancel;
  logic        busy, done, err;
  logic [3:0]  rd_idx;
  logic        rd_e, rd_g;
  logic [9:0]  rd_asid;
  logic [18:0] rd_vppn;
  logic [5:0]  rd_ps;
  logic        clr_we;
  logic [3:0]  clr_idx;

  logic        tlb_e    [16];
  logic        tlb_g    [16];
  logic [9:0]  tlb_asid [16];
  logic [18:0] tlb_vppn [16];
  logic [5:0]  tlb_ps   [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tlb_inv_walker dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_asid  (req_asid),
    .req_va    (req_va),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_idx    (rd_idx),
    .rd_e      (rd_e),
    .rd_g      (rd_g),
    .rd_asid   (rd_asid),
    .rd_vppn   (rd_vppn),
    .rd_ps     (rd_ps),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  always_comb begin
    rd_e    = tlb_e[rd_idx];
    rd_g    = tlb_g[rd_idx];
    rd_asid = tlb_asid[rd_idx];
    rd_vppn = tlb_vppn[rd_idx];
    rd_ps   = tlb_ps[rd_idx];
  end

  typedef struct {
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [31:0] va;
    int          img;
    logic [15:0] mask;
    logic        err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ent(input int i, input logic e, input logic g, input logic [9:0] a,
                         input logic [31:0] va, input logic [5:0] ps);
    tlb_e[i] = e; tlb_g[i] = g; tlb_asid[i] = a; tlb_vppn[i] = va[31:13]; tlb_ps[i] = ps;
  endtask

  // img 0: mixed entries exercising every predicate; img 1: all 16 valid.
  task automatic load_image(input int img);
    for (int i = 0; i < 16; i++) set_ent(i, 1'b0, 1'b0, 10'd0, 32'd0, 6'd12);
    if (img == 1) begin
      for (int i = 0; i < 16; i++) set_ent(i, 1'b1, i[0], 10'(i), 32'(i) << 13, 6'd12);
    end else begin
      set_ent(0, 1'b1, 1'b0, 10'd5, 32'h1234_5000, 6'd12);
      set_ent(1, 1'b1, 1'b1, 10'd5, 32'h1234_5000, 6'd12);
      set_ent(2, 1'b1, 1'b1, 10'd1, 32'h1230_0000, 6'd21);
      set_ent(3, 1'b1, 1'b0, 10'd5, 32'h0000_0000, 6'd12);
      set_ent(4, 1'b1, 1'b0, 10'd1, 32'h1234_6000, 6'd12);
      set_ent(5, 1'b0, 1'b0, 10'd5, 32'h1234_5000, 6'd12);
      set_ent(6, 1'b1, 1'b0, 10'd6, 32'h1234_5000, 6'd12);
      set_ent(7, 1'b1, 1'b1, 10'd5, 32'h0000_0000, 6'd12);
      set_ent(8, 1'b1, 1'b0, 10'd5, 32'h1234_5000, 6'd14);
      set_ent(9, 1'b1, 1'b0, 10'd6, 32'h0000_0000, 6'd12);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [9:0] asid, input logic [31:0] va);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_asid = asid; req_va = va;
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [9:0] asid,
                        input logic [31:0] va, input logic [15:0] exp_mask, input logic exp_err);
    logic [15:0] mask;
    int lat, done_cnt, order_bad;
    logic err_seen;
    mask = '0; lat = -1; done_cnt = 0; order_bad = 0; err_seen = 1'b0;
    @(negedge clk);
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
    issue(op, asid, va);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (clr_we) begin
        mask[clr_idx] = 1'b1;
        if (32'(clr_idx) != 32'(k - 1)) order_bad++;
      end
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = k;
        err_seen = err;
      end
    end
    chk({name, "_mask"}, 32'(mask), 32'(exp_mask));
    chk({name, "_err"}, 32'(err_seen), 32'(exp_err));
    chk({name, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'd17);
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, "_clr_order"}, 32'(order_bad), 32'd0);
  endtask

  initial begin
    logic [15:0] mask;
    int dcnt;
    vecs[0]  = '{5'd0,  10'd0, 32'h0,         1, 16'hFFFF, 1'b0};
    vecs[1]  = '{5'd0,  10'd0, 32'h0,         0, 16'h03DF, 1'b0};
    vecs[2]  = '{5'd1,  10'd0, 32'h0,         0, 16'h03DF, 1'b0};
    vecs[3]  = '{5'd2,  10'd0, 32'h0,         0, 16'h0086, 1'b0};
    vecs[4]  = '{5'd3,  10'd0, 32'h0,         0, 16'h0359, 1'b0};
    vecs[5]  = '{5'd4,  10'd5, 32'h0,         0, 16'h0109, 1'b0};
    vecs[6]  = '{5'd5,  10'd5, 32'h1234_5000, 0, 16'h0001, 1'b0};
    vecs[7]  = '{5'd6,  10'd1, 32'h1234_5000, 0, 16'h0006, 1'b0};
    vecs[8]  = '{5'd6,  10'd6, 32'h1234_5000, 0, 16'h0046, 1'b0};
    vecs[9]  = '{5'd5,  10'd6, 32'h1234_5000, 0, 16'h0040, 1'b0};
    vecs[10] = '{5'd7,  10'd0, 32'h0,         1, 16'h0000, 1'b1};
    vecs[11] = '{5'd31, 10'd3, 32'hFFFF_F000, 1, 16'h0000, 1'b1};

    resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_asid = '0; req_va = '0; cancel = 1'b0;
    load_image(1);

    // Outputs while reset is held, then ready only after the first edge.
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_clr", {27'd0, clr_we, clr_idx}, 32'd0);
    chk("rst_rd_idx", 32'(rd_idx), 32'd0);
    resetn = 1'b1;
    #1 chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready_after_edge", 32'(req_ready), 32'd1);

    for (int v = 0; v < 12; v++) begin
      load_image(vecs[v].img);
      run_op($sformatf("vec%0d_op%0d", v, vecs[v].op), vecs[v].op, vecs[v].asid,
             vecs[v].va, vecs[v].mask, vecs[v].err);
    end

    // Cancel at counter 5 during op 0.
    load_image(1);
    mask = '0; dcnt = 0;
    issue(5'd0, 10'd0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (clr_we) mask[clr_idx] = 1'b1;
    end
    @(negedge clk);
    cancel = 1'b1;
    #1 chk("cancel_clr_we", 32'(clr_we), 32'd0);
    chk("cancel_rd_idx", 32'(rd_idx), 32'd5);
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_ready", 32'(req_ready), 32'd1);
    chk("cancel_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 20; k++) begin
      if (clr_we) mask[clr_idx] = 1'b1;
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("cancel_mask", 32'(mask), 32'h001F);
    chk("cancel_no_done", 32'(dcnt), 32'd0);

    // Cancel in DONE suppresses the done/err pulse.
    issue(5'd7, 10'd0, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    cancel = 1'b1;
    #1 chk("cancel_done_pulse", {30'd0, done, err}, 32'd0);
    chk("cancel_done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_done_ready", 32'(req_ready), 32'd1);

    // Cancel together with req_valid in IDLE still accepts the request.
    issue(5'd2, 10'd0, 32'h0);
    cancel = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; cancel = 1'b0;
    chk("idle_cancel_accept", 32'(busy), 32'd1);
    dcnt = 0;
    for (int k = 0; k < 20 && dcnt == 0; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("idle_cancel_completes", 32'(dcnt), 32'd1);

    // Reset pulse at counter 8, then a fresh op 1 runs to completion.
    load_image(1);
    issue(5'd0, 10'd0, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("midrst_pre_clr", {27'd0, clr_we, clr_idx}, {27'd0, 1'b1, 4'd8});
    #1 resetn = 1'b0;
    #1 chk("midrst_clr_drop", 32'(clr_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_idx", 32'(rd_idx), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_idle_ready", 32'(req_ready), 32'd1);
    run_op("post_rst_op1", 5'd1, 10'd0, 32'h0, 16'hFFFF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
